// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the per-PE context sequencer: context word layout,
// the NOP context and the sequencer state encoding.
package pe_ctx_pkg;

  localparam int CTX_DEPTH = 16;
  localparam int CTX_AW    = 4;
  localparam int ITER_W    = 16;
  localparam int CTX_W     = 64;

  // Field layout of a context word, LSB offset and width of each field
  localparam int FU_OP_LSB      = 59;
  localparam int FU_OP_W        = 5;
  localparam int CTRL_IN_LSB    = 50;
  localparam int CTRL_IN_W      = 9;
  localparam int CTRL_OUT_LSB   = 41;
  localparam int CTRL_OUT_W     = 9;
  localparam int PUT_IN_LSB     = 35;
  localparam int PUT_IN_W       = 6;
  localparam int PUT_OUT_LSB    = 29;
  localparam int PUT_OUT_W      = 6;
  localparam int REG_1_LSB      = 23;
  localparam int REG_1_W        = 6;
  localparam int REG_2_LSB      = 17;
  localparam int REG_2_W        = 6;
  localparam int SEND_LSB       = 11;
  localparam int SEND_W         = 6;
  localparam int PE2FU_1_LSB    = 7;
  localparam int PE2FU_1_W      = 4;
  localparam int PE2FU_2_LSB    = 3;
  localparam int PE2FU_2_W      = 4;
  localparam int WRITE_BACK_BIT = 2;
  localparam int LD_BIT         = 1;
  localparam int LD_WRITE_BIT   = 0;

  typedef logic [CTX_W-1:0] ctx_word_t;
  typedef logic [1:0]       state_t;

  // Bubble word: ld=1 and both PE-to-FU selects at 4'b1111 give zero
  // operands, every write enable is low so the register file is untouched.
  localparam ctx_word_t NOP_CTX = 64'h0000_0000_0000_07FA;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pe_ctx_mem.sv
// Context memory: CTX_DEPTH words of 64 bits, one synchronous write port and
// one combinational read port. Contents survive reset on purpose.
module pe_ctx_mem
  import pe_ctx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [CTX_AW-1:0] i_waddr,
  input  ctx_word_t         i_wdata,
  input  logic [CTX_AW-1:0] i_raddr,
  output ctx_word_t         o_rdata
);

  ctx_word_t r_mem [CTX_DEPTH];

  // Commit a config write on the clock edge
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pe_ctx_sequencer.sv
// Per-PE context sequencer. Loads context words over the config port and, on
// start, issues one context per clock for the programmed number of loop
// iterations. The issued word is registered on posedge so the downstream
// register file can sample it on negedge.
module pe_ctx_sequencer
  import pe_ctx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              cfg_we,
  input  logic [CTX_AW-1:0] cfg_addr,
  input  logic [CTX_W-1:0]  cfg_data,
  input  logic              start,
  input  logic [CTX_AW-1:0] ctx_last,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CTX_AW-1:0] ctx_pc,
  output logic [4:0]        fu_op,
  output logic [8:0]        control_in,
  output logic [8:0]        control_out,
  output logic [5:0]        control_put_in,
  output logic [5:0]        control_put_out,
  output logic [5:0]        control_reg_1,
  output logic [5:0]        control_reg_2,
  output logic [5:0]        control_send,
  output logic [3:0]        control_pe2fu_1,
  output logic [3:0]        control_pe2fu_2,
  output logic              write_back,
  output logic              ld,
  output logic              ld_write
);

  state_t            r_state;
  ctx_word_t         r_ctx;
  logic [CTX_AW-1:0] r_pc;
  logic [CTX_AW-1:0] r_last;
  logic [ITER_W-1:0] r_iter_left;
  logic              r_cfg_err;

  state_t            w_next_state;
  ctx_word_t         w_next_ctx;
  logic [CTX_AW-1:0] w_next_pc;
  logic [CTX_AW-1:0] w_next_last;
  logic [ITER_W-1:0] w_next_iter;
  logic [CTX_AW-1:0] w_raddr;
  ctx_word_t         w_rdata;
  logic              w_not_run;
  logic              w_mem_we;
  logic              w_cfg_drop;

  // Writes only land outside RUN, and a start in the same cycle wins over them
  assign w_not_run  = (r_state != ST_RUN);
  assign w_mem_we   = cfg_we && w_not_run && !start;
  assign w_cfg_drop = cfg_we && !w_mem_we;

  pe_ctx_mem u_mem (
    .i_clk   (CLK),
    .i_we    (w_mem_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Next-state logic: choose which context (or bubble) goes out next cycle
  always_comb begin
    w_next_state = r_state;
    w_next_ctx   = NOP_CTX;
    w_next_pc    = r_pc;
    w_next_last  = r_last;
    w_next_iter  = r_iter_left;
    w_raddr      = '0;
    case (r_state)
      ST_RUN: begin
        if (stall) begin
          w_next_ctx = NOP_CTX;
        end else if (r_pc != r_last) begin
          w_next_pc  = r_pc + CTX_AW'(1);
          w_raddr    = r_pc + CTX_AW'(1);
          w_next_ctx = w_rdata;
        end else if (r_iter_left == ITER_W'(1)) begin
          w_next_state = ST_DONE;
          w_next_pc    = '0;
        end else begin
          w_next_iter = r_iter_left - ITER_W'(1);
          w_next_pc   = '0;
          w_raddr     = '0;
          w_next_ctx  = w_rdata;
        end
      end
      default: begin
        w_next_pc = '0;
        if (start) begin
          if (iter_count == '0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_RUN;
            w_next_last  = ctx_last;
            w_next_iter  = iter_count;
            w_raddr      = '0;
            w_next_ctx   = w_rdata;
          end
        end
      end
    endcase
  end

  // State, counters and the output context register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_ctx       <= NOP_CTX;
      r_pc        <= '0;
      r_last      <= '0;
      r_iter_left <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ctx       <= w_next_ctx;
      r_pc        <= w_next_pc;
      r_last      <= w_next_last;
      r_iter_left <= w_next_iter;
      r_cfg_err   <= w_cfg_drop;
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign cfg_err = r_cfg_err;
  assign ctx_pc  = r_pc;

  assign fu_op           = r_ctx[FU_OP_LSB   +: FU_OP_W];
  assign control_in      = r_ctx[CTRL_IN_LSB +: CTRL_IN_W];
  assign control_out     = r_ctx[CTRL_OUT_LSB +: CTRL_OUT_W];
  assign control_put_in  = r_ctx[PUT_IN_LSB  +: PUT_IN_W];
  assign control_put_out = r_ctx[PUT_OUT_LSB +: PUT_OUT_W];
  assign control_reg_1   = r_ctx[REG_1_LSB   +: REG_1_W];
  assign control_reg_2   = r_ctx[REG_2_LSB   +: REG_2_W];
  assign control_send    = r_ctx[SEND_LSB    +: SEND_W];
  assign control_pe2fu_1 = r_ctx[PE2FU_1_LSB +: PE2FU_1_W];
  assign control_pe2fu_2 = r_ctx[PE2FU_2_LSB +: PE2FU_2_W];
  assign write_back      = r_ctx[WRITE_BACK_BIT];
  assign ld              = r_ctx[LD_BIT];
  assign ld_write        = r_ctx[LD_WRITE_BIT];

endmodule

// File: tb/tb_pe_ctx_sequencer.sv
// Self-checking bench for pe_ctx_sequencer: a queue-based issue model checked
// every cycle, plus directed sequences with hand-computed expectations.
module tb_pe_ctx_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_data;
  logic        start;
  logic [3:0]  ctx_last;
  logic [15:0] iter_count;
  logic        stall;
  logic        busy, done, cfg_err;
  logic [3:0]  ctx_pc;
  logic [4:0]  fu_op;
  logic [8:0]  control_in, control_out;
  logic [5:0]  control_put_in, control_put_out, control_reg_1, control_reg_2, control_send;
  logic [3:0]  control_pe2fu_1, control_pe2fu_2;
  logic        write_back, ld, ld_write;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] TB_NOP = {5'd0, 9'd0, 9'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                                    4'hF, 4'hF, 1'b0, 1'b1, 1'b0};
  localparam logic [63:0] W15 = {5'h15, 9'h1A3, 9'h0C6, 6'h2D, 6'h12, 6'h3F, 6'h01,
                                 6'h2A, 4'h9, 4'h6, 1'b1, 1'b0, 1'b1};

  always #5 CLK = ~CLK;

  pe_ctx_sequencer dut (
    .CLK             (CLK),
    .RST             (RST),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .start           (start),
    .ctx_last        (ctx_last),
    .iter_count      (iter_count),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .ctx_pc          (ctx_pc),
    .fu_op           (fu_op),
    .control_in      (control_in),
    .control_out     (control_out),
    .control_put_in  (control_put_in),
    .control_put_out (control_put_out),
    .control_reg_1   (control_reg_1),
    .control_reg_2   (control_reg_2),
    .control_send    (control_send),
    .control_pe2fu_1 (control_pe2fu_1),
    .control_pe2fu_2 (control_pe2fu_2),
    .write_back      (write_back),
    .ld              (ld),
    .ld_write        (ld_write)
  );

  wire [63:0] dutWord = {fu_op, control_in, control_out, control_put_in, control_put_out,
                         control_reg_1, control_reg_2, control_send, control_pe2fu_1,
                         control_pe2fu_2, write_back, ld, ld_write};

  logic [63:0] words [16];

  // Behavioural model: a pending queue of context indices to issue
  logic [63:0] mMem [16];
  int          seq[$];
  bit          mBusy, mDone, mErr, modelValid;
  logic [63:0] mWord;
  int          mPc;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    if (RST) begin
      seq.delete();
      mBusy = 0; mDone = 0; mErr = 0; mWord = TB_NOP; mPc = 0; modelValid = 1;
    end else if (modelValid) begin
      if (!mBusy) begin
        mErr = cfg_we && start;
        mPc  = 0;
        mWord = TB_NOP;
        if (start) begin
          if (iter_count == 0) begin
            mDone = 1;
          end else begin
            seq.delete();
            for (int it = 0; it < int'(iter_count); it++)
              for (int c = 0; c <= int'(ctx_last); c++) seq.push_back(c);
            mPc = seq.pop_front();
            mWord = mMem[mPc];
            mBusy = 1; mDone = 0;
          end
        end else if (cfg_we) begin
          mMem[cfg_addr] = cfg_data;
        end
      end else begin
        mErr = cfg_we;
        if (stall) begin
          mWord = TB_NOP;
        end else if (seq.size() == 0) begin
          mBusy = 0; mDone = 1; mWord = TB_NOP; mPc = 0;
        end else begin
          mPc = seq.pop_front();
          mWord = mMem[mPc];
        end
      end
    end
  endtask

  // Advance the model on each edge and compare DUT outputs just after it
  always @(posedge CLK) begin
    modelStep();
    #1;
    if (modelValid) begin
      checkOutput("word", dutWord, mWord);
      checkOutput("ctx_pc", 64'(ctx_pc), 64'(mPc));
      checkOutput("busy", 64'(busy), 64'(mBusy));
      checkOutput("done", 64'(done), 64'(mDone));
      checkOutput("cfg_err", 64'(cfg_err), 64'(mErr));
    end
  end

  task automatic applyStimulus(input logic [3:0] last, input logic [15:0] iters,
                               input int stallAt, input int stallLen,
                               input int expCycles, input bit checkW15);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    @(negedge CLK);
    start = 1; ctx_last = last; iter_count = iters;
    @(negedge CLK);
    start = 0;
    while (busy && n < 200) begin
      n++;
      if (checkW15 && ctx_pc == 4'd15 && dutWord !== TB_NOP && !seen) begin
        seen = 1;
        checkOutput("w15.fu_op", 64'(fu_op), 64'h15);
        checkOutput("w15.control_in", 64'(control_in), 64'h1A3);
        checkOutput("w15.control_out", 64'(control_out), 64'h0C6);
        checkOutput("w15.put_in", 64'(control_put_in), 64'h2D);
        checkOutput("w15.put_out", 64'(control_put_out), 64'h12);
        checkOutput("w15.reg_1", 64'(control_reg_1), 64'h3F);
        checkOutput("w15.reg_2", 64'(control_reg_2), 64'h01);
        checkOutput("w15.send", 64'(control_send), 64'h2A);
        checkOutput("w15.pe2fu_1", 64'(control_pe2fu_1), 64'h9);
        checkOutput("w15.pe2fu_2", 64'(control_pe2fu_2), 64'h6);
        checkOutput("w15.flags", {61'd0, write_back, ld, ld_write}, 64'h5);
      end
      stall = (n >= stallAt) && (n < stallAt + stallLen);
      @(negedge CLK);
    end
    stall = 0;
    checkOutput("issueCycles", 64'(n), 64'(expCycles));
    checkOutput("doneAfterRun", 64'(done), 64'd1);
    checkOutput("nopAfterRun", dutWord, TB_NOP);
    if (checkW15) checkOutput("w15Seen", 64'(seen), 64'd1);
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1; cfg_we = 0; cfg_addr = 0; cfg_data = 0; start = 0;
    ctx_last = 0; iter_count = 0; stall = 0;
    for (int i = 0; i < 16; i++) begin
      words[i] = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
      mMem[i]  = '0;
    end
    words[15] = W15;
    repeat (2) @(negedge CLK);
    RST = 0;
    checkOutput("reset.word", dutWord, TB_NOP);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.done", 64'(done), 64'd0);
    checkOutput("reset.pc", 64'(ctx_pc), 64'd0);

    for (int i = 0; i < 16; i++) begin
      cfg_we = 1; cfg_addr = 4'(i); cfg_data = words[i];
      @(negedge CLK);
    end
    cfg_we = 0;

    $display("[TB] basic loop: 3 contexts x 2 iterations");
    applyStimulus(4'd2, 16'd2, 0, 0, 6, 0);

    $display("[TB] two stall bubbles after the first context");
    applyStimulus(4'd2, 16'd2, 1, 2, 8, 0);

    $display("[TB] zero iterations");
    pulseReset();
    checkOutput("preZero.done", 64'(done), 64'd0);
    applyStimulus(4'd2, 16'd0, 0, 0, 0, 0);
    checkOutput("zero.ld", 64'(ld), 64'd1);
    checkOutput("zero.pe2fu", {56'd0, control_pe2fu_1, control_pe2fu_2}, 64'hFF);
    checkOutput("zero.write_back", 64'(write_back), 64'd0);

    $display("[TB] full depth, one iteration");
    applyStimulus(4'd15, 16'd1, 0, 0, 16, 1);

    $display("[TB] dropped config writes");
    @(negedge CLK);
    start = 1; ctx_last = 4'd2; iter_count = 16'd3;
    cfg_we = 1; cfg_addr = 4'd1; cfg_data = 64'hDEAD_BEEF_0000_0001;
    @(negedge CLK);
    start = 0; cfg_we = 0;
    checkOutput("startWrite.cfg_err", 64'(cfg_err), 64'd1);
    checkOutput("startWrite.word0", dutWord, words[0]);
    @(negedge CLK);
    checkOutput("run.word1", dutWord, words[1]);
    checkOutput("run.cfg_err_idle", 64'(cfg_err), 64'd0);
    cfg_we = 1; cfg_addr = 4'd1; cfg_data = 64'hDEAD_BEEF_0000_0002;
    @(negedge CLK);
    cfg_we = 0;
    checkOutput("runWrite.cfg_err", 64'(cfg_err), 64'd1);
    begin
      int guard;
      guard = 0;
      while (busy && guard < 50) begin
        guard++;
        @(negedge CLK);
      end
      checkOutput("drainRun", 64'(busy), 64'd0);
    end
    applyStimulus(4'd2, 16'd1, 0, 0, 3, 0);

    $display("[TB] reset in the middle of a run");
    @(negedge CLK);
    start = 1; ctx_last = 4'd2; iter_count = 16'd2;
    @(negedge CLK);
    start = 0;
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    checkOutput("midReset.word", dutWord, TB_NOP);
    checkOutput("midReset.busy", 64'(busy), 64'd0);
    checkOutput("midReset.pc", 64'(ctx_pc), 64'd0);
    applyStimulus(4'd2, 16'd2, 0, 0, 6, 0);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
